// File: rtl/ysyx_22050550_mul_pkg.sv
// Shared definitions for the radix-4 Booth multiplier:
// FSM state encodings, the Booth digit type and the 3-bit recoder.
package ysyx_22050550_mul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_POS1,
        BD_POS2,
        BD_NEG1,
        BD_NEG2
    } booth_t;

    // Bits are {y[2i+1], y[2i], y[2i-1]}.
    function automatic booth_t booth_recode(input logic [2:0] b);
        booth_t r;
        case (b)
            3'b001, 3'b010: r = BD_POS1;
            3'b011:         r = BD_POS2;
            3'b100:         r = BD_NEG2;
            3'b101, 3'b110: r = BD_NEG1;
            default:        r = BD_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050550_booth_step.sv
// One combinational Booth iteration: add the selected partial product
// into the accumulator's upper WM+1 bits, then shift right by 2.
// Ports: en_i (0 = pass acc through), digit_i, mcand_i (WM bits),
//        acc_i / acc_o (2*WM+1 bits).
module ysyx_22050550_booth_step
    import ysyx_22050550_mul_pkg::*;
#(
    parameter int WM = 66
) (
    input  logic          en_i,
    input  booth_t        digit_i,
    input  logic [WM-1:0] mcand_i,
    input  logic [2*WM:0] acc_i,
    output logic [2*WM:0] acc_o
);

    logic [WM:0] m1;
    logic [WM:0] m2;
    logic [WM:0] pp;
    logic [WM:0] hi;

    always_comb begin
        m1 = {mcand_i[WM-1], mcand_i};
        m2 = {mcand_i, 1'b0};
        pp = '0;
        case (digit_i)
            BD_POS1: pp = m1;
            BD_POS2: pp = m2;
            BD_NEG1: pp = -m1;
            BD_NEG2: pp = -m2;
            default: pp = '0;
        endcase
        hi = acc_i[2*WM:WM] + pp;
        if (en_i) begin
            acc_o = {{2{hi[WM]}}, hi, acc_i[WM-1:2]};
        end else begin
            acc_o = acc_i;
        end
    end

endmodule

// File: rtl/ysyx_22050550_booth_mult.sv
// Multi-cycle radix-4 Booth multiplier covering MUL/MULH/MULHSU/MULHU/MULW.
// Ports: clock, reset (async active-low); request io_Exu_MulValid/MulReady,
//        io_Exu_Flush, io_Exu_Mulw, io_Exu_MulSigned[1:0], operands;
//        result io_Exu_OutValid/OutReady, io_Exu_ResultH/ResultL.
module ysyx_22050550_booth_mult
    import ysyx_22050550_mul_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int STEPS = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_Exu_MulValid,
    output logic            io_Exu_MulReady,
    input  logic            io_Exu_Flush,
    input  logic            io_Exu_Mulw,
    input  logic [1:0]      io_Exu_MulSigned,
    input  logic [XLEN-1:0] io_Exu_Multiplicand,
    input  logic [XLEN-1:0] io_Exu_Multiplier,
    output logic            io_Exu_OutValid,
    input  logic            io_Exu_OutReady,
    output logic [XLEN-1:0] io_Exu_ResultH,
    output logic [XLEN-1:0] io_Exu_ResultL
);

    // Hardware is sized for normal mode; word mode uses the same datapath
    // with fewer digits, leaving the product offset by WM-34 bits.
    localparam int WM  = XLEN + 2;
    localparam int AW  = 2 * WM + 1;
    localparam int MW  = WM + 1 + 2 * STEPS;
    localparam int DN  = WM / 2;
    localparam int DW  = 17;
    localparam int CW  = $clog2(DN + 1);
    localparam int CN  = (DN + STEPS - 1) / STEPS;
    localparam int CWD = (DW + STEPS - 1) / STEPS;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WM-1:0]   mcand_q, mcand_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] resh_q, resh_d;
    logic [XLEN-1:0] resl_q, resl_d;

    logic [WM-1:0]   ext_a, ext_b;
    logic            word_in;
    logic [XLEN-1:0] map_h, map_l;
    logic [AW-1:0]   acc_nx;
    logic [CW-1:0]   cnt_last;
    logic            accept;

    logic [STEPS-1:0] en;
    booth_t           digit [STEPS];
    logic [AW-1:0]    chain [STEPS+1];

    logic unused_acc;
    assign unused_acc = ^acc_nx[AW-1:2*XLEN];

    logic sa, sb;
    assign sa = io_Exu_MulSigned[1];
    assign sb = io_Exu_MulSigned[0];

    if (XLEN >= 32) begin : g_word
        logic [63:0] pw;
        logic [WM-1:0] wa, wb, na, nb;
        assign word_in = io_Exu_Mulw;
        assign wa = {{(WM-32){sa & io_Exu_Multiplicand[31]}},
                     io_Exu_Multiplicand[31:0]};
        assign wb = {{(WM-32){sb & io_Exu_Multiplier[31]}},
                     io_Exu_Multiplier[31:0]};
        assign na = {{2{sa & io_Exu_Multiplicand[XLEN-1]}},
                     io_Exu_Multiplicand};
        assign nb = {{2{sb & io_Exu_Multiplier[XLEN-1]}},
                     io_Exu_Multiplier};
        assign ext_a = word_in ? wa : na;
        assign ext_b = word_in ? wb : nb;
        assign pw = acc_nx[WM-34 +: 64];
        assign map_l = word_q ? XLEN'($signed(pw[31:0]))
                              : acc_nx[XLEN-1:0];
        assign map_h = word_q ? XLEN'($signed(pw[63:32]))
                              : acc_nx[2*XLEN-1:XLEN];
    end else begin : g_noword
        logic unused_w;
        assign unused_w = io_Exu_Mulw;
        assign word_in = 1'b0;
        assign ext_a = {{2{sa & io_Exu_Multiplicand[XLEN-1]}},
                        io_Exu_Multiplicand};
        assign ext_b = {{2{sb & io_Exu_Multiplier[XLEN-1]}},
                        io_Exu_Multiplier};
        assign map_l = acc_nx[XLEN-1:0];
        assign map_h = acc_nx[2*XLEN-1:XLEN];
    end

    assign chain[0] = acc_q;
    assign acc_nx   = chain[STEPS];

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        // Digits past the last one in the final cycle are bypassed.
        assign en[k] = (int'(cnt_q) * STEPS + k)
                       < (word_q ? DW : DN);
        assign digit[k] = booth_recode(mplier_q[2*k+2:2*k]);
        ysyx_22050550_booth_step #(
            .WM (WM)
        ) u_step (
            .en_i    (en[k]),
            .digit_i (digit[k]),
            .mcand_i (mcand_q),
            .acc_i   (chain[k]),
            .acc_o   (chain[k+1])
        );
    end

    assign cnt_last = word_q ? CW'(CWD - 1) : CW'(CN - 1);
    assign accept   = io_Exu_MulValid & ~io_Exu_Flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        word_d   = word_q;
        resh_d   = resh_q;
        resl_d   = resl_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = ext_a;
                    // Appended 0 is the implicit y[-1] of digit 0.
                    mplier_d = {{(2*STEPS){ext_b[WM-1]}}, ext_b, 1'b0};
                    word_d   = word_in;
                end
            end
            ST_BUSY: begin
                if (io_Exu_Flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_nx;
                    mplier_d = MW'($signed(mplier_q) >>> (2 * STEPS));
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == cnt_last) begin
                        state_d = ST_DONE;
                        resh_d  = map_h;
                        resl_d  = map_l;
                    end
                end
            end
            ST_DONE: begin
                if (io_Exu_Flush || io_Exu_OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            word_q   <= 1'b0;
            resh_q   <= '0;
            resl_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            word_q   <= word_d;
            resh_q   <= resh_d;
            resl_q   <= resl_d;
        end
    end

    assign io_Exu_MulReady = (state_q == ST_IDLE);
    assign io_Exu_OutValid = (state_q == ST_DONE);
    assign io_Exu_ResultH  = resh_q;
    assign io_Exu_ResultL  = resl_q;

endmodule

// File: tb/tb_ysyx_22050550_booth_mult.sv
// Testbench for ysyx_22050550_booth_mult: three configurations
// (64/1, 64/2, 32/4) driven with directed and random vectors.
module tb_ysyx_22050550_booth_mult;

    logic clk;
    logic rst_n;

    logic [2:0]  v, fl, mw, ordy;
    logic [1:0]  sg [3];
    logic [63:0] opa [3];
    logic [63:0] opb [3];

    logic        mrdy0, mrdy1, mrdy2;
    logic        ovld0, ovld1, ovld2;
    logic [63:0] rh0, rl0, rh1, rl1;
    logic [31:0] rh2, rl2;

    int errs;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050550_booth_mult #(.XLEN(64), .STEPS(1)) u0 (
        .clock               (clk),
        .reset               (rst_n),
        .io_Exu_MulValid     (v[0]),
        .io_Exu_MulReady     (mrdy0),
        .io_Exu_Flush        (fl[0]),
        .io_Exu_Mulw         (mw[0]),
        .io_Exu_MulSigned    (sg[0]),
        .io_Exu_Multiplicand (opa[0]),
        .io_Exu_Multiplier   (opb[0]),
        .io_Exu_OutValid     (ovld0),
        .io_Exu_OutReady     (ordy[0]),
        .io_Exu_ResultH      (rh0),
        .io_Exu_ResultL      (rl0)
    );

    ysyx_22050550_booth_mult #(.XLEN(64), .STEPS(2)) u1 (
        .clock               (clk),
        .reset               (rst_n),
        .io_Exu_MulValid     (v[1]),
        .io_Exu_MulReady     (mrdy1),
        .io_Exu_Flush        (fl[1]),
        .io_Exu_Mulw         (mw[1]),
        .io_Exu_MulSigned    (sg[1]),
        .io_Exu_Multiplicand (opa[1]),
        .io_Exu_Multiplier   (opb[1]),
        .io_Exu_OutValid     (ovld1),
        .io_Exu_OutReady     (ordy[1]),
        .io_Exu_ResultH      (rh1),
        .io_Exu_ResultL      (rl1)
    );

    ysyx_22050550_booth_mult #(.XLEN(32), .STEPS(4)) u2 (
        .clock               (clk),
        .reset               (rst_n),
        .io_Exu_MulValid     (v[2]),
        .io_Exu_MulReady     (mrdy2),
        .io_Exu_Flush        (fl[2]),
        .io_Exu_Mulw         (mw[2]),
        .io_Exu_MulSigned    (sg[2]),
        .io_Exu_Multiplicand (opa[2][31:0]),
        .io_Exu_Multiplier   (opb[2][31:0]),
        .io_Exu_OutValid     (ovld2),
        .io_Exu_OutReady     (ordy[2]),
        .io_Exu_ResultH      (rh2),
        .io_Exu_ResultL      (rl2)
    );

    function automatic logic get_rdy(input int u);
        return (u == 0) ? mrdy0 : (u == 1) ? mrdy1 : mrdy2;
    endfunction

    function automatic logic get_vld(input int u);
        return (u == 0) ? ovld0 : (u == 1) ? ovld1 : ovld2;
    endfunction

    function automatic logic [63:0] get_h(input int u);
        return (u == 0) ? rh0 : (u == 1) ? rh1 : {32'b0, rh2};
    endfunction

    function automatic logic [63:0] get_l(input int u);
        return (u == 0) ? rl0 : (u == 1) ? rl1 : {32'b0, rl2};
    endfunction

    function automatic int xlen_of(input int u);
        return (u == 2) ? 32 : 64;
    endfunction

    function automatic int steps_of(input int u);
        return (u == 0) ? 1 : (u == 1) ? 2 : 4;
    endfunction

    function automatic int lat_exp(input int u, input logic w);
        int d;
        d = w ? 17 : (xlen_of(u) + 2) / 2;
        return (d + steps_of(u) - 1) / steps_of(u) + 1;
    endfunction

    // Exact arithmetic reference: extend, multiply, then map.
    task automatic ref_mul(input int xl, input logic w,
                           input logic [1:0] s,
                           input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] h, output logic [63:0] l);
        int n;
        logic signed [129:0] ea, eb, p;
        n = w ? 32 : xl;
        for (int i = 0; i < 130; i++) begin
            ea[i] = (i < n) ? a[i] : (s[1] & a[n-1]);
            eb[i] = (i < n) ? b[i] : (s[0] & b[n-1]);
        end
        p = ea * eb;
        if (w) begin
            l = {{32{p[31]}}, p[31:0]};
            h = {{32{p[63]}}, p[63:32]};
        end else begin
            l = p[63:0];
            h = 64'(p >>> n);
        end
        if (xl == 32) begin
            l = l & 64'hFFFF_FFFF;
            h = h & 64'hFFFF_FFFF;
        end
    endtask

    task automatic start_op(input int u, input logic w,
                            input logic [1:0] s,
                            input logic [63:0] a, input logic [63:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_rdy(u) && n < 100) begin
            @(negedge clk);
            n++;
        end
        v[u]   = 1'b1;
        mw[u]  = w;
        sg[u]  = s;
        opa[u] = a;
        opb[u] = b;
        @(posedge clk);
        #1;
        v[u]   = 1'b0;
        opa[u] = ~a;
        opb[u] = ~b;
        mw[u]  = ~w;
    endtask

    task automatic wait_done(input int u, output int lat);
        lat = 1;
        while (!get_vld(u) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack(input int u);
        ordy[u] = 1'b1;
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
    endtask

    task automatic check_op(input string nm, input int u, input logic w,
                            input logic [1:0] s,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] eh, input logic [63:0] el);
        int lat;
        start_op(u, w, s, a, b);
        wait_done(u, lat);
        checks++;
        if (lat !== lat_exp(u, w)) begin
            errs++;
            $display("FAIL %s latency got=%0d want=%0d", nm, lat,
                     lat_exp(u, w));
        end
        checks++;
        if (get_h(u) !== eh) begin
            errs++;
            $display("FAIL %s ResultH got=%h want=%h", nm, get_h(u), eh);
        end
        checks++;
        if (get_l(u) !== el) begin
            errs++;
            $display("FAIL %s ResultL got=%h want=%h", nm, get_l(u), el);
        end
        ack(u);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v = '0; fl = '0; mw = '0; ordy = '0;
        for (int i = 0; i < 3; i++) begin
            sg[i] = 2'b00; opa[i] = '0; opb[i] = '0;
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({mrdy0, mrdy1, mrdy2} !== 3'b111) begin
            errs++;
            $display("FAIL reset MulReady got=%b want=111",
                     {mrdy0, mrdy1, mrdy2});
        end
        checks++;
        if ({ovld0, ovld1, ovld2} !== 3'b000) begin
            errs++;
            $display("FAIL reset OutValid got=%b want=000",
                     {ovld0, ovld1, ovld2});
        end
        checks++;
        if ({rh0, rl0, rh1, rl1, rh2, rl2} !== '0) begin
            errs++;
            $display("FAIL reset results got=%h %h want=0", rh0, rl0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        check_op("s11_m3x7", 0, 1'b0, 2'b11, -64'sd3, 64'd7,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB);
        check_op("u00_max", 0, 1'b0, 2'b00, '1, '1,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'h1);
        check_op("su10_max", 0, 1'b0, 2'b10, '1, '1,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        check_op("mulw_s11", 0, 1'b1, 2'b11, 64'h7FFF_FFFF, 64'd2,
                 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        check_op("s2_m3x7", 1, 1'b0, 2'b11, -64'sd3, 64'd7,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB);
    endtask

    task automatic test_hold();
        int lat;
        start_op(0, 1'b0, 2'b11, 64'd100, -64'sd5);
        wait_done(0, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!(ovld0 === 1'b1 && mrdy0 === 1'b0 &&
                  rh0 === 64'hFFFF_FFFF_FFFF_FFFF &&
                  rl0 === 64'hFFFF_FFFF_FFFF_FE0C)) begin
                errs++;
                $display("FAIL hold cyc%0d vld=%b rdy=%b h=%h l=%h want 1 0 all-F FE0C",
                         i, ovld0, mrdy0, rh0, rl0);
            end
        end
        // Request offered during the accepting DONE cycle must wait.
        ordy[0] = 1'b1;
        v[0]    = 1'b1;
        mw[0]   = 1'b0;
        sg[0]   = 2'b00;
        opa[0]  = 64'h1_0000_0000;
        opb[0]  = 64'h3_0000_0000;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        checks++;
        if (!(mrdy0 === 1'b1 && ovld0 === 1'b0)) begin
            errs++;
            $display("FAIL hold_release rdy=%b vld=%b want 1 0",
                     mrdy0, ovld0);
        end
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        wait_done(0, lat);
        checks++;
        if (lat !== 34 || rh0 !== 64'h3 || rl0 !== 64'h0) begin
            errs++;
            $display("FAIL second_req lat=%0d h=%h l=%h want 34 3 0",
                     lat, rh0, rl0);
        end
        ack(0);
    endtask

    task automatic test_flush();
        logic seen;
        int lat;
        start_op(0, 1'b0, 2'b11, 64'd5, 64'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        fl[0] = 1'b1;
        @(posedge clk);
        #1;
        fl[0] = 1'b0;
        checks++;
        if (!(mrdy0 === 1'b1 && ovld0 === 1'b0)) begin
            errs++;
            $display("FAIL flush_busy rdy=%b vld=%b want 1 0", mrdy0, ovld0);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ovld0 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL flush_no_valid got=%b want=0", seen);
        end
        @(negedge clk);
        fl[0] = 1'b1;
        v[0]  = 1'b1;
        @(posedge clk);
        #1;
        fl[0] = 1'b0;
        v[0]  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (mrdy0 !== 1'b1 || ovld0 !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL flush_with_valid accepted got=%b want=0", seen);
        end
        start_op(0, 1'b0, 2'b11, 64'd2, 64'd3);
        wait_done(0, lat);
        fl[0]   = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        fl[0]   = 1'b0;
        ordy[0] = 1'b0;
        checks++;
        if (!(mrdy0 === 1'b1 && ovld0 === 1'b0)) begin
            errs++;
            $display("FAIL flush_done rdy=%b vld=%b want 1 0", mrdy0, ovld0);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(0, 1'b0, 2'b11, 64'd9, 64'd9);
        wait_done(0, lat);
        ack(0);
        start_op(0, 1'b0, 2'b11, 64'd4, 64'd4);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!(mrdy0 === 1'b1 && ovld0 === 1'b0 &&
              rl0 === 64'h0 && rh0 === 64'h0)) begin
            errs++;
            $display("FAIL reset_mid rdy=%b vld=%b l=%h want 1 0 0",
                     mrdy0, ovld0, rl0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset", 0, 1'b0, 2'b11, 64'd6, 64'd7,
                 64'h0, 64'd42);
    endtask

    task automatic test_random();
        logic [63:0] a, b, eh, el;
        logic w;
        logic [1:0] s;
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 8; i++) begin
                w = (i >= 4);
                s = 2'(i);
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                if (i == 0) a = 64'h8000_0000_8000_0000;
                if (i == 5) b = 64'hFFFF_FFFF_8000_0000;
                if (u == 2) begin
                    a = a & 64'hFFFF_FFFF;
                    b = b & 64'hFFFF_FFFF;
                end
                ref_mul(xlen_of(u), w, s, a, b, eh, el);
                check_op($sformatf("rand_u%0d_%0d", u, i), u, w, s,
                         a, b, eh, el);
            end
        end
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
